sp_mem_arbiter: RTL and testbench

//   Shares one single-port SRAM (sp_mem_model, fixed RD_LATENCY) among N_REQ

---
 rtl/sp_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_sp_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_mem_arbiter.sv
// rtl/sp_mem_arbiter.sv - round-robin arbiter sharing one single-port SRAM, with read tagging and sleep control
module sp_mem_arbiter #(
    parameter int DATA_L     = 32,
    parameter int ADDR_L     = 10,
    parameter int RD_LATENCY = 1,
    parameter int N_REQ      = 2,
    parameter int IDLE_TH    = 16,
    parameter int WAKE_CYC   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic [N_REQ-1:0]          req_wr,
    input  logic [N_REQ*ADDR_L-1:0]   req_addr,
    input  logic [N_REQ*DATA_L-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_rdy,
    output logic                      rsp_vld,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [DATA_L-1:0]         rsp_data,
    output logic                      mem_ch_en,
    output logic                      mem_wr_en,
    output logic [ADDR_L-1:0]         mem_addr,
    output logic [DATA_L-1:0]         mem_wr_data,
    input  logic [DATA_L-1:0]         mem_rd_data,
    output logic                      mem_slp,
    output logic                      mem_sd
);
    localparam int IW   = $clog2(N_REQ);
    localparam int CMAX = (IDLE_TH > WAKE_CYC) ? IDLE_TH : WAKE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        ptr;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 slp_q, slp_n;
    logic                 rst_q;
    logic [RD_LATENCY-1:0] tag_vld;
    logic [IW-1:0]        tag_id [RD_LATENCY];
    logic                 found;
    logic [IW-1:0]        gnt;
    logic                 grant;
    logic                 busy;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_vld[IW'((int'(ptr) + k) % N_REQ)]) begin
                found = 1'b1;
                gnt   = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    // No grants during reset or the first cycle after it.
    assign grant = (state == ST_ACTIVE) && !rst && !rst_q && found;
    assign busy  = (|req_vld) || (|tag_vld);

    // The shared counter tracks idle cycles in ACTIVE and wake cycles in WAKE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        slp_n   = slp_q;
        case (state)
            ST_ACTIVE: begin
                if (busy) begin
                    cnt_n = '0;
                end else begin
                    if (cnt != CW'(CMAX)) cnt_n = cnt + 1'b1;
                    if (IDLE_TH > 0 && cnt == CW'(IDLE_TH - 1)) begin
                        state_n = ST_SLEEP;
                        slp_n   = 1'b1;
                        cnt_n   = '0;
                    end
                end
            end
            ST_SLEEP: begin
                if (|req_vld) begin
                    state_n = ST_WAKE;
                    slp_n   = 1'b0;
                    cnt_n   = '0;
                end
            end
            ST_WAKE: begin
                if (cnt == CW'(WAKE_CYC - 1)) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_ACTIVE;
        endcase
    end

    always_comb begin
        req_rdy = '0;
        if (grant) req_rdy[gnt] = 1'b1;
    end

    assign mem_ch_en   = grant;
    assign mem_wr_en   = grant && req_wr[gnt];
    assign mem_addr    = grant ? req_addr[int'(gnt)*ADDR_L +: ADDR_L] : '0;
    assign mem_wr_data = grant ? req_wdata[int'(gnt)*DATA_L +: DATA_L] : '0;
    assign rsp_vld     = tag_vld[RD_LATENCY-1] && !rst;
    assign rsp_id      = rsp_vld ? tag_id[RD_LATENCY-1] : '0;
    assign rsp_data    = mem_rd_data;
    assign mem_slp     = slp_q && !rst;
    assign mem_sd      = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ACTIVE;
            ptr     <= '0;
            cnt     <= '0;
            slp_q   <= 1'b0;
            rst_q   <= 1'b1;
            tag_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag_id[i] <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            slp_q <= slp_n;
            rst_q <= 1'b0;
            if (grant) ptr <= (int'(gnt) == N_REQ - 1) ? '0 : gnt + 1'b1;
            tag_vld[0] <= grant && !req_wr[gnt];
            tag_id[0]  <= gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end
endmodule

// File: tb/tb_sp_mem_arbiter.sv
// tb/tb_sp_mem_arbiter.sv - self-checking bench for sp_mem_arbiter against a cycle-level reference model
module tb_sp_mem_arbiter;
    localparam int DL = 32, AL = 10, N = 2, IDLE = 16, WAKE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_vld, req_wr, req_rdy;
    logic [N*AL-1:0] req_addr;
    logic [N*DL-1:0] req_wdata;
    logic            rsp_vld, mem_ch_en, mem_wr_en, mem_slp, mem_sd;
    logic [0:0]      rsp_id;
    logic [DL-1:0]   rsp_data, mem_wr_data, mem_rd_data;
    logic [AL-1:0]   mem_addr;

    logic            b_rst;
    logic [N-1:0]    b_req_vld, b_req_wr, b_req_rdy;
    logic [N*AL-1:0] b_req_addr;
    logic [N*DL-1:0] b_req_wdata;
    logic            b_rsp_vld, b_mem_ch_en, b_mem_wr_en, b_mem_slp, b_mem_sd;
    logic [0:0]      b_rsp_id;
    logic [DL-1:0]   b_rsp_data, b_mem_wr_data, b_mem_rd_data, b_rd1;
    logic [AL-1:0]   b_mem_addr;

    sp_mem_arbiter #(.DATA_L(DL), .ADDR_L(AL), .RD_LATENCY(1), .N_REQ(N), .IDLE_TH(IDLE), .WAKE_CYC(WAKE)) dut_a (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .mem_ch_en(mem_ch_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_slp(mem_slp), .mem_sd(mem_sd));

    sp_mem_arbiter #(.DATA_L(DL), .ADDR_L(AL), .RD_LATENCY(2), .N_REQ(N), .IDLE_TH(0), .WAKE_CYC(WAKE)) dut_b (
        .clk(clk), .rst(b_rst), .req_vld(b_req_vld), .req_wr(b_req_wr), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_rdy(b_req_rdy), .rsp_vld(b_rsp_vld), .rsp_id(b_rsp_id),
        .rsp_data(b_rsp_data), .mem_ch_en(b_mem_ch_en), .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr),
        .mem_wr_data(b_mem_wr_data), .mem_rd_data(b_mem_rd_data), .mem_slp(b_mem_slp), .mem_sd(b_mem_sd));

    // SRAM models: A has 1-cycle read latency, B has 2.
    logic [DL-1:0] sram_a [1<<AL];
    logic [DL-1:0] sram_b [1<<AL];
    bit            mem_init;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < (1<<AL); i++) begin
                sram_a[i] <= 32'hA5A50000 ^ DL'(i);
                sram_b[i] <= 32'hA5A50000 ^ DL'(i);
            end
            mem_init <= 1'b1;
        end else begin
            if (mem_ch_en && mem_wr_en)  sram_a[mem_addr] <= mem_wr_data;
            if (mem_ch_en && !mem_wr_en) mem_rd_data <= sram_a[mem_addr];
            if (b_mem_ch_en && b_mem_wr_en)  sram_b[b_mem_addr] <= b_mem_wr_data;
            if (b_mem_ch_en && !b_mem_wr_en) b_rd1 <= sram_b[b_mem_addr];
            b_mem_rd_data <= b_rd1;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model for DUT A: expected responses as a queue keyed by due cycle.
    typedef struct { int due; int id; logic [DL-1:0] data; } rsp_t;
    rsp_t          q[$];
    logic [DL-1:0] ref_mem [1<<AL];
    int            cyc = 0, ptr_m = 0, idle_m = 0, wake_m = 0;
    bit            sleep_m = 0, hold_m = 0;

    task automatic model_check();
        bit busy, rv, gok, eslp;
        int g;
        logic [N-1:0] erdy;
        logic ech, ewr;
        logic [AL-1:0] eaddr;
        logic [DL-1:0] ewd;
        if (rst) begin
            chk("rst_rdy", 64'(req_rdy), 64'(0));
            chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
            chk("rst_ch_en", 64'(mem_ch_en), 64'(0));
            chk("rst_wr_en", 64'(mem_wr_en), 64'(0));
            chk("rst_slp", 64'(mem_slp), 64'(0));
            chk("rst_addr", 64'(mem_addr), 64'(0));
            chk("rst_wdata", 64'(mem_wr_data), 64'(0));
            chk("rst_rsp_id", 64'(rsp_id), 64'(0));
            q.delete();
            ptr_m = 0; idle_m = 0; sleep_m = 0; wake_m = 0; hold_m = 1;
            cyc++;
            return;
        end
        busy = (req_vld != '0) || (q.size() != 0);
        rv   = (q.size() != 0) && (q[0].due == cyc);
        chk("rsp_vld", 64'(rsp_vld), 64'(rv));
        if (rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
            void'(q.pop_front());
        end
        erdy = '0; ech = 0; ewr = 0; eaddr = '0; ewd = '0; eslp = sleep_m;
        if (sleep_m) begin
            if (req_vld != '0) begin sleep_m = 0; wake_m = WAKE; end
        end else if (wake_m > 0) begin
            wake_m--;
            if (wake_m == 0) idle_m = 0;
        end else begin
            gok = 0; g = 0;
            if (!hold_m)
                for (int k = 0; k < N; k++)
                    if (!gok && req_vld[(ptr_m + k) % N]) begin gok = 1; g = (ptr_m + k) % N; end
            if (gok) begin
                erdy[g] = 1'b1; ech = 1'b1; ewr = req_wr[g];
                eaddr = req_addr[g*AL +: AL]; ewd = req_wdata[g*DL +: DL];
                if (ewr) ref_mem[eaddr] = ewd;
                else q.push_back('{due: cyc + 1, id: g, data: ref_mem[eaddr]});
                ptr_m = (g + 1) % N;
            end
            if (busy) idle_m = 0; else idle_m++;
            if (idle_m == IDLE) begin sleep_m = 1; idle_m = 0; end
        end
        chk("req_rdy", 64'(req_rdy), 64'(erdy));
        chk("mem_ch_en", 64'(mem_ch_en), 64'(ech));
        chk("mem_wr_en", 64'(mem_wr_en), 64'(ewr));
        if (ech) begin
            chk("mem_addr", 64'(mem_addr), 64'(eaddr));
            chk("mem_wr_data", 64'(mem_wr_data), 64'(ewd));
        end
        chk("mem_slp", 64'(mem_slp), 64'(eslp));
        chk("mem_sd", 64'(mem_sd), 64'(0));
        hold_m = 0;
        cyc++;
    endtask

    task automatic sample_a(); @(negedge clk); model_check(); endtask
    task automatic adv();      @(posedge clk); #1;          endtask
    task automatic step_a();   sample_a(); adv();            endtask

    task automatic set_a(input int i, input bit v, input bit w, input logic [AL-1:0] a, input logic [DL-1:0] d);
        req_vld[i] = v; req_wr[i] = w; req_addr[i*AL +: AL] = a; req_wdata[i*DL +: DL] = d;
    endtask

    task automatic set_b(input int i, input bit v, input bit w, input logic [AL-1:0] a, input logic [DL-1:0] d);
        b_req_vld[i] = v; b_req_wr[i] = w; b_req_addr[i*AL +: AL] = a; b_req_wdata[i*DL +: DL] = d;
    endtask

    initial begin
        for (int i = 0; i < (1<<AL); i++) ref_mem[i] = 32'hA5A50000 ^ DL'(i);
        rst = 1; req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        b_rst = 1; b_req_vld = '0; b_req_wr = '0; b_req_addr = '0; b_req_wdata = '0;
        adv();
        step_a(); step_a();

        // Write then read back through requester 0; the first post-reset cycle grants nothing.
        rst = 0;
        set_a(0, 1, 1, 10'h005, 32'hDEADBEEF);
        sample_a(); chk("hold_rdy", 64'(req_rdy), 64'(0)); adv();
        sample_a(); chk("t1_wr", 64'({mem_ch_en, mem_wr_en}), 64'(2'b11)); adv();
        set_a(0, 1, 0, 10'h005, '0);
        step_a();
        set_a(0, 0, 0, '0, '0);
        sample_a();
        chk("t1_rsp_vld", 64'(rsp_vld), 64'(1));
        chk("t1_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));
        adv();

        // Both requesters read continuously; pointer sits at 1 after two grants to requester 0.
        for (int i = 0; i < 8; i++) begin
            set_a(0, 1, 0, AL'(16 + i), '0);
            set_a(1, 1, 0, AL'(32 + i), '0);
            sample_a();
            chk("t2_alt", 64'(req_rdy), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            adv();
        end
        set_a(0, 0, 0, '0, '0); set_a(1, 0, 0, '0, '0);
        step_a();

        // Idle into sleep, then wake on a requester 1 read.
        for (int i = 0; i < IDLE; i++) step_a();
        set_a(1, 1, 0, 10'h021, '0);
        sample_a(); chk("t3_slp", 64'(mem_slp), 64'(1)); chk("t3_rdy0", 64'(req_rdy), 64'(0)); adv();
        sample_a(); chk("t3_wake_slp", 64'(mem_slp), 64'(0)); chk("t3_rdy1", 64'(req_rdy), 64'(0)); adv();
        sample_a(); chk("t3_rdy2", 64'(req_rdy), 64'(0)); adv();
        sample_a(); chk("t3_grant", 64'(req_rdy), 64'(2'b10)); adv();
        set_a(1, 0, 0, '0, '0);
        step_a();

        // Write granted while an earlier read to the same address returns.
        set_a(0, 1, 0, 10'h007, '0);
        step_a();
        set_a(0, 0, 0, '0, '0);
        set_a(1, 1, 1, 10'h007, 32'hCAFEF00D);
        sample_a();
        chk("t4_old_data", 64'(rsp_data), 64'(32'hA5A50007));
        chk("t4_wr_en", 64'(mem_wr_en), 64'(1));
        adv();
        set_a(1, 0, 0, '0, '0);
        set_a(0, 1, 0, 10'h007, '0);
        step_a();
        set_a(0, 0, 0, '0, '0);
        sample_a(); chk("t4_new_data", 64'(rsp_data), 64'(32'hCAFEF00D)); adv();

        // Randomized traffic with idle gaps long enough to sleep and occasional resets.
        for (int c = 0; c < 500; c++) begin
            int dens;
            dens = ((c % 60) >= 35) ? 0 : (((c / 100) % 2 == 0) ? 70 : 25);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++)
                set_a(i, $urandom_range(0, 99) < dens, 1'($urandom), AL'($urandom_range(0, 7)), $urandom);
            step_a();
        end
        rst = 0; req_vld = '0;
        for (int i = 0; i < 4; i++) step_a();

        // DUT B (2-cycle latency, sleep disabled): reset with a read in flight.
        b_rst = 0;
        set_b(0, 1, 1, 10'h010, 32'h12345678);
        @(negedge clk); chk("b_hold_rdy", 64'(b_req_rdy), 64'(0)); adv();
        @(negedge clk); chk("b_wr", 64'({b_mem_ch_en, b_mem_wr_en, b_req_rdy}), 64'(4'b1101)); adv();
        set_b(0, 1, 0, 10'h010, '0);
        @(negedge clk); chk("b_rd_issue", 64'({b_mem_ch_en, b_mem_wr_en}), 64'(2'b10)); adv();
        set_b(0, 0, 0, '0, '0);
        b_rst = 1;
        @(negedge clk);
        chk("b_rst_outs", 64'({b_req_rdy, b_rsp_vld, b_mem_ch_en, b_mem_wr_en, b_mem_slp, b_rsp_id, b_mem_sd}), 64'(0));
        chk("b_rst_addr", 64'({b_mem_addr, b_mem_wr_data}), 64'(0));
        adv();
        b_rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("b_no_rsp", 64'(b_rsp_vld), 64'(0)); adv();
        end

        // Read latency of 2 cycles on B.
        set_b(0, 1, 0, 10'h010, '0);
        @(negedge clk); chk("b_rd2_grant", 64'(b_req_rdy), 64'(2'b01)); adv();
        set_b(0, 0, 0, '0, '0);
        @(negedge clk); chk("b_lat_early", 64'(b_rsp_vld), 64'(0)); adv();
        @(negedge clk);
        chk("b_lat_vld", 64'(b_rsp_vld), 64'(1));
        chk("b_lat_id", 64'(b_rsp_id), 64'(0));
        chk("b_lat_data", 64'(b_rsp_data), 64'(32'h12345678));
        adv();

        // Sleep disabled: long idle never raises slp, and a request is granted at once.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("b_no_slp", 64'(b_mem_slp), 64'(0));
            chk("b_sd", 64'(b_mem_sd), 64'(0));
            adv();
        end
        set_b(1, 1, 0, 10'h011, '0);
        @(negedge clk); chk("b_post_idle_grant", 64'(b_req_rdy), 64'(2'b10)); adv();
        set_b(1, 0, 0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
